// File: rtl/noise_step_sequencer_pkg.sv
// noise_step_sequencer_pkg: shared sizes, state encoding and tick clamp for the noise step sequencer.
package noise_step_sequencer_pkg;
  localparam int NUM_VOICES = 4;
  localparam int NUM_STEPS = 16;
  localparam int STEP_IDX_W = 4;
  localparam int TICK_W = 24;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;
  typedef logic [NUM_VOICES-1:0] voiceMask_t;
  function automatic logic [TICK_W-1:0] clampTicks(input logic [TICK_W-1:0] t);
    return (t < TICK_W'(2)) ? TICK_W'(2) : t;
  endfunction
endpackage

// File: rtl/noise_step_sequencer_if.sv
// noise_step_sequencer_if: control, pattern-write and voice output bundle of the sequencer.
interface noise_step_sequencer_if;
  import noise_step_sequencer_pkg::*;
  logic start;
  logic stop;
  logic [TICK_W-1:0] step_ticks;
  logic [TICK_W-1:0] gate_ticks;
  logic [STEP_IDX_W-1:0] loop_last;
  logic pat_we;
  logic [STEP_IDX_W-1:0] pat_addr;
  logic [NUM_VOICES-1:0] pat_data;
  logic [NUM_VOICES-1:0] voice_en;
  logic [NUM_VOICES-1:0] voice_retrig;
  logic step_pulse;
  logic [STEP_IDX_W-1:0] step_idx;
  logic playing;
  modport master(
    output start, stop, step_ticks, gate_ticks, loop_last, pat_we, pat_addr, pat_data,
    input voice_en, voice_retrig, step_pulse, step_idx, playing
  );
  modport slave(
    input start, stop, step_ticks, gate_ticks, loop_last, pat_we, pat_addr, pat_data,
    output voice_en, voice_retrig, step_pulse, step_idx, playing
  );
endinterface

// File: rtl/noise_step_sequencer_step_timer.sv
// step_timer: per-step tick counter with latched step/gate lengths and step-end / next-gate flags.
module step_timer
  import noise_step_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic run,
  input  logic [TICK_W-1:0] stepTicks,
  input  logic [TICK_W-1:0] gateTicks,
  output logic stepEnd,
  output logic gateNext
);
  logic [TICK_W-1:0] cnt, stl, gtl;
  assign stepEnd = cnt == stl - TICK_W'(1);
  // gate state the counter will be in after this edge
  assign gateNext = load ? (gateTicks != '0) : (cnt + TICK_W'(1) < gtl);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      stl <= '0;
      gtl <= '0;
    end else if (clear) begin
      cnt <= '0;
      stl <= '0;
      gtl <= '0;
    end else if (load) begin
      cnt <= '0;
      stl <= clampTicks(stepTicks);
      gtl <= gateTicks;
    end else if (run) begin
      cnt <= cnt + TICK_W'(1);
    end
endmodule

// File: rtl/noise_step_sequencer.sv
// noise_step_sequencer: 16-step pattern player issuing per-voice retrigger pulses and timed gates.
module noise_step_sequencer
  import noise_step_sequencer_pkg::*;
(
  input logic clk,
  input logic reset,
  noise_step_sequencer_if.slave bus
);
  logic [0:0] state;
  logic [STEP_IDX_W-1:0] stepIdx, nextIdx;
  voiceMask_t pattern [NUM_STEPS];
  voiceMask_t curMask, fetched;
  logic stepEnd, gateNext, load;
  assign load = !bus.stop && ((state == IDLE) ? bus.start : stepEnd);
  assign nextIdx = (state == IDLE || stepIdx >= bus.loop_last) ? '0 : stepIdx + STEP_IDX_W'(1);
  assign fetched = pattern[nextIdx];
  assign bus.playing = state == PLAY;
  assign bus.step_idx = stepIdx;
  step_timer u_timer (
    .clk(clk),
    .reset(reset),
    .clear(bus.stop),
    .load(load),
    .run(state == PLAY),
    .stepTicks(bus.step_ticks),
    .gateTicks(bus.gate_ticks),
    .stepEnd(stepEnd),
    .gateNext(gateNext)
  );
  // curMask snapshots the fetched step so later pattern writes leave the sounding step alone
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
      state <= IDLE;
      stepIdx <= '0;
      curMask <= '0;
      bus.voice_en <= '0;
      bus.voice_retrig <= '0;
      bus.step_pulse <= 1'b0;
    end else begin
      if (bus.pat_we) pattern[bus.pat_addr] <= bus.pat_data;
      if (bus.stop) begin
        state <= IDLE;
        stepIdx <= '0;
        curMask <= '0;
        bus.voice_en <= '0;
        bus.voice_retrig <= '0;
        bus.step_pulse <= 1'b0;
      end else if (load) begin
        state <= PLAY;
        stepIdx <= nextIdx;
        curMask <= fetched;
        bus.step_pulse <= 1'b1;
        bus.voice_retrig <= (bus.gate_ticks != '0) ? fetched : '0;
        bus.voice_en <= (bus.gate_ticks != '0) ? fetched : '0;
      end else begin
        bus.step_pulse <= 1'b0;
        bus.voice_retrig <= '0;
        bus.voice_en <= gateNext ? curMask : '0;
      end
    end
endmodule

// File: tb/tb_noise_step_sequencer.sv
// tb_noise_step_sequencer: directed and random stimulus against a step/phase reference model.
module tb_noise_step_sequencer;
  import noise_step_sequencer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  noise_step_sequencer_if bus();
  noise_step_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  int mPat [NUM_STEPS];
  bit mPlay;
  int mIdx, mPhase, mStl, mGtl, mMask;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic modelReset();
    foreach (mPat[i]) mPat[i] = 0;
    mPlay = 0; mIdx = 0; mPhase = 0; mStl = 0; mGtl = 0; mMask = 0;
  endtask
  task automatic beginStep();
    mPhase = 0;
    mStl = (bus.step_ticks < 2) ? 2 : int'(bus.step_ticks);
    mGtl = int'(bus.gate_ticks);
    mMask = mPat[mIdx];
  endtask
  task automatic modelEdge();
    if (bus.stop) begin
      mPlay = 0; mIdx = 0; mPhase = 0; mMask = 0;
    end else if (!mPlay) begin
      if (bus.start) begin
        mPlay = 1; mIdx = 0; beginStep();
      end
    end else if (mPhase == mStl - 1) begin
      mIdx = (mIdx >= int'(bus.loop_last)) ? 0 : mIdx + 1;
      beginStep();
    end else mPhase++;
    if (bus.pat_we) mPat[bus.pat_addr] = int'(bus.pat_data);
  endtask
  task automatic checkOutputs();
    check("playing", 32'(bus.playing), 32'(mPlay));
    check("step_idx", 32'(bus.step_idx), mPlay ? mIdx : 0);
    check("step_pulse", 32'(bus.step_pulse), 32'(mPlay && mPhase == 0));
    check("voice_en", 32'(bus.voice_en), (mPlay && mPhase < mGtl) ? mMask : 0);
    check("voice_retrig", 32'(bus.voice_retrig), (mPlay && mPhase == 0 && mGtl != 0) ? mMask : 0);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutputs();
    end
  endtask
  task automatic writePat(input int a, input int d);
    bus.pat_we = 1'b1;
    bus.pat_addr = STEP_IDX_W'(a);
    bus.pat_data = NUM_VOICES'(d);
    tick(1);
    bus.pat_we = 1'b0;
  endtask
  task automatic pulseStart();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  task automatic stopPlay();
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask
  task automatic waitStep(input int k, input int ph);
    for (int i = 0; i < 400 && !(mPlay && mIdx == k && mPhase == ph); i++) tick(1);
    check("wait_step", 32'(mPlay && mIdx == k && mPhase == ph && bus.step_idx == STEP_IDX_W'(k)), 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.start = 0; bus.stop = 0; bus.pat_we = 0; bus.pat_addr = '0; bus.pat_data = '0;
    bus.step_ticks = 24'd10; bus.gate_ticks = 24'd4; bus.loop_last = 4'd1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutputs();
    reset = 1'b0;
    writePat(0, 4'b0001);
    writePat(1, 4'b1010);
    pulseStart();
    tick(45);
    stopPlay();
    bus.gate_ticks = 24'd0;
    pulseStart();
    tick(25);
    stopPlay();
    writePat(1, 4'b0001);
    bus.gate_ticks = 24'd20;
    pulseStart();
    tick(40);
    stopPlay();
    bus.step_ticks = 24'd0; bus.gate_ticks = 24'd1;
    pulseStart();
    tick(10);
    stopPlay();
    for (int i = 2; i < NUM_STEPS; i++) writePat(i, i);
    bus.step_ticks = 24'd3; bus.gate_ticks = 24'd2; bus.loop_last = 4'd15;
    pulseStart();
    waitStep(7, 0);
    bus.loop_last = 4'd2;
    tick(20);
    stopPlay();
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(3);
    bus.start = 1'b0; bus.stop = 1'b0;
    tick(2);
    pulseStart();
    tick(4);
    bus.start = 1'b1;
    tick(12);
    bus.start = 1'b0;
    stopPlay();
    pulseStart();
    tick(3);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    tick(3);
    bus.step_ticks = 24'd6; bus.gate_ticks = 24'd6; bus.loop_last = 4'd15;
    pulseStart();
    waitStep(3, 1);
    writePat(3, 4'b1111);
    writePat(4, 4'b0100);
    tick(NUM_STEPS * 6 + 6);
    waitStep(5, 5);
    writePat(6, 4'b1001);
    tick(10);
    stopPlay();
    pulseStart();
    tick(7);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutputs();
    #2 reset = 1'b0;
    pulseStart();
    tick(40);
    stopPlay();
    for (int i = 0; i < 1500; i++) begin
      bus.start = $urandom_range(0, 9) == 0;
      bus.stop = $urandom_range(0, 39) == 0;
      bus.pat_we = $urandom_range(0, 3) == 0;
      bus.pat_addr = STEP_IDX_W'($urandom);
      bus.pat_data = NUM_VOICES'($urandom);
      bus.step_ticks = TICK_W'($urandom_range(0, 7));
      bus.gate_ticks = TICK_W'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) bus.loop_last = STEP_IDX_W'($urandom);
      tick(1);
    end
    bus.start = 0; bus.stop = 0; bus.pat_we = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/noise_step_sequencer.md
Name: noise_step_sequencer

Overview:
- Step sequencer that schedules the four noise voices (G4/A4/B4/C4 LFSR channels) from a programmable 16-step pattern at a runtime tempo.
- Per step it issues a one-cycle retrigger per active voice, which reseeds that voice's LFSR, and holds a gate enable for a programmable number of clocks.
- voice_en replaces the static switch gating on the gpio outputs.
- Sits between the board switches/config logic and the per-voice lfsr/squareWave/edgeDetector chains.

Parameters:
- NUM_VOICES, 4, voices controlled; one pattern bit per voice.
- NUM_STEPS, 16, pattern depth; power of two.
- STEP_IDX_W, 4, log2(NUM_STEPS).
- TICK_W, 24, width of tempo/gate tick counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state and the pattern.
- start  in  1  level/pulse; begins playback from step 0 when idle.
- stop  in  1  halts playback; wins over start.
- step_ticks  in  TICK_W  clocks per step; latched at each step start.
- gate_ticks  in  TICK_W  clocks voice_en stays high per step; latched at each step start.
- loop_last  in  STEP_IDX_W  last step index before wrap to 0.
- pat_we  in  1  pattern write strobe.
- pat_addr  in  STEP_IDX_W  pattern step written.
- pat_data  in  NUM_VOICES  voice mask for that step.
- voice_en  out  NUM_VOICES  gate per voice; AND with lfsr q[0].
- voice_retrig  out  NUM_VOICES  one-cycle LFSR reseed pulse per voice.
- step_pulse  out  1  one-cycle pulse at each step start.
- step_idx  out  STEP_IDX_W  current step.
- playing  out  1  high in PLAY state.

Behaviour:
- All outputs registered. Reset values: voice_en=0, voice_retrig=0, step_pulse=0, step_idx=0, playing=0. Pattern memory all-zero. State IDLE. Counters 0.
- States: IDLE, PLAY.
- IDLE->PLAY when start=1 and stop=0 at edge N.
  - Edge N loads step 0, cnt=0, latches stl=max(step_ticks,2) and gtl=gate_ticks.
  - Step-start outputs for step 0 are visible in the cycle following edge N.
- start while in PLAY: ignored (no restart).
- Step start (cnt=0):
  - step_pulse=1.
  - voice_retrig = pattern[step_idx] if gtl!=0, else 0.
  - voice_en = pattern[step_idx] if gtl!=0.
- Within a step:
  - cnt increments each clock.
  - voice_en holds its mask while cnt<gtl and clears at cnt=gtl.
  - gtl>=stl: voice_en stays continuously high across consecutive steps where the voice is set (legato); retrig still pulses each step.
- Step end at cnt=stl-1:
  - Next edge sets cnt=0.
  - step_idx becomes 0 if step_idx>=loop_last, else step_idx+1. This also covers loop_last lowered below the current index at runtime.
  - step_ticks and gate_ticks are re-latched on that edge.
- PLAY->IDLE when stop=1. At the next edge all outputs go to reset values and step_idx=0. Pattern is preserved.
- Pattern write:
  - Synchronous on pat_we, allowed in any state.
  - Fetch of a step reads the pre-write value if the write and fetch land in the same cycle and address; the new value applies on the next visit.
  - A write to the currently sounding step does not alter in-flight voice_en.
- reset mid-step: immediate asynchronous clear of everything including the pattern.
- Counter widths: TICK_W unsigned, no overflow, because cnt < stl <= 2^TICK_W-1.

Decomposition:
- Shared package: NUM_VOICES, NUM_STEPS, STEP_IDX_W, TICK_W defaults, and the state encoding constants IDLE=0, PLAY=1.
- One natural sub-module: step_timer (tick counter, stl/gtl latching, step_end and gate_active flags).
- Sequencer FSM, pattern register file and output registers stay in the top.

Test Plan:
- Reset state: pattern write then reset mid-PLAY -> all outputs 0 immediately; replay shows an all-zero pattern, so voice_en stays 0 for every step.
- Basic timing: pattern[0]=4'b0001, pattern[1]=4'b1010, step_ticks=10, gate_ticks=4, loop_last=1, start pulse ->
  - step_pulse every 10 clocks.
  - voice_en=0001 for 4 clocks, then 0 for 6 clocks.
  - Then 1010 for 4 clocks, with retrig pulsing one cycle at each step start.
  - step_idx sequence 0,1,0,1.
- Boundaries: gate_ticks=0 -> voice_en and voice_retrig never assert while step_pulse continues. gate_ticks=20 with step_ticks=10 and voice 0 set in steps 0 and 1 -> voice_en[0] high continuously, with retrig each step. step_ticks=0 -> steps every 2 clocks.
- Loop wrap: loop_last=15, then lower loop_last to 2 while at step 7 -> after step 7 step_idx=0, then 0,1,2,0.
- Control conflicts: start and stop asserted together in IDLE -> stays IDLE. stop during PLAY -> next cycle playing=0, voice_en=0, step_idx=0. start then replays from step 0.
- Pattern write: while step 3 sounds, write pattern[3]=1111 and pattern[4]=0100 -> current voice_en unchanged, step 4 plays 0100, the next visit to step 3 plays 1111. A write coincident with the fetch of the same step -> old data plays.
